// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/register-read stage feeding the 18-bit ALU.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_inst    instruction word in; in_ready is the only combinational output
//   out_valid/out_ready registered operand bundle handshake
//   SRC1, SRC2, IMM     registered operands and raw immediate
//   mux1_select         1 = ALU uses sign-extended IMM
//   mux2_select         00 add, 01 and, 10 nand, 11 nor
//   out_rd              destination register carried with the bundle
//   wb_en/addr/data     writeback port; writes the regfile and clears the busy bit
//   illegal_op          one-cycle pulse after an illegal opcode is consumed
module alu_issue_stage #(
    parameter int NREGS = 16,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_inst,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SRC1,
    output logic [WIDTH-1:0] SRC2,
    output logic [5:0]       IMM,
    output logic             mux1_select,
    output logic [1:0]       mux2_select,
    output logic [3:0]       out_rd,
    input  logic             wb_en,
    input  logic [3:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             illegal_op
);
    logic [WIDTH-1:0] rf_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d, wb_hit, ebusy;
    logic             valid_q, valid_d, ill_q, m1_q;
    logic [WIDTH-1:0] src1_q, src2_q, src1_v, src2_v;
    logic [5:0]       imm_q;
    logic [1:0]       m2_q, sel2;
    logic [3:0]       rd_q, op, rd, rs1, rs2;
    logic             legal, is_imm, hazard, fire, issue;

    assign op  = in_inst[17:14];
    assign rd  = in_inst[13:10];
    assign rs1 = in_inst[9:6];
    assign rs2 = in_inst[5:2];
    assign legal  = op < 4'd6;
    // ADDI (0001) and ANDI (0011) are the only odd opcodes below 0100
    assign is_imm = legal & op[0] & ~op[2];
    assign sel2   = op[2] ? {1'b1, op[0]} : {1'b0, op[1]};

    // a writeback this cycle retires the pending write, so it cannot cause a hazard
    assign wb_hit = wb_en ? (NREGS'(1) << wb_addr) : '0;
    assign ebusy  = busy_q & ~wb_hit;
    assign hazard = ebusy[rs1] | ebusy[rd] | (~is_imm & ebusy[rs2]);

    assign in_ready = (~valid_q | out_ready) & ~(legal & hazard);
    assign fire     = in_valid & in_ready;
    assign issue    = fire & legal;

    assign src1_v = (wb_en && wb_addr == rs1) ? wb_data : rf_q[rs1];
    assign src2_v = (wb_en && wb_addr == rs2) ? wb_data : rf_q[rs2];

    // issue sets after writeback clears, so a same-register collision stays busy
    assign busy_d  = ebusy | (issue ? (NREGS'(1) << rd) : '0);
    assign valid_d = issue | (valid_q & ~out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
            src1_q  <= '0;
            src2_q  <= '0;
            imm_q   <= '0;
            m1_q    <= 1'b0;
            m2_q    <= '0;
            rd_q    <= '0;
            busy_q  <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            ill_q   <= fire & ~legal;
            busy_q  <= busy_d;
            if (issue) begin
                src1_q <= src1_v;
                src2_q <= is_imm ? '0 : src2_v;
                imm_q  <= is_imm ? in_inst[5:0] : '0;
                m1_q   <= is_imm;
                m2_q   <= sel2;
                rd_q   <= rd;
            end
            if (wb_en) rf_q[wb_addr] <= wb_data;
        end
    end

    assign out_valid   = valid_q;
    assign SRC1        = src1_q;
    assign SRC2        = src2_q;
    assign IMM         = imm_q;
    assign mux1_select = m1_q;
    assign mux2_select = m2_q;
    assign out_rd      = rd_q;
    assign illegal_op  = ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed plan plus randomized traffic against a behavioural model.
module tb_alu_issue_stage;
    logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [17:0] in_inst, SRC1, SRC2, wb_data;
    logic [5:0]  IMM;
    logic        mux1_select, illegal_op, wb_en;
    logic [1:0]  mux2_select;
    logic [3:0]  out_rd, wb_addr;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .SRC1(SRC1), .SRC2(SRC2), .IMM(IMM),
        .mux1_select(mux1_select), .mux2_select(mux2_select), .out_rd(out_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int unsigned m_rf [16];
    bit          m_busy [16];
    bit          m_valid, m_ill, m_m1;
    int unsigned m_src1, m_src2, m_imm, m_m2, m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] enc(input int op, input int rd, input int rs1, input int rs2);
        return 18'((op << 14) | (rd << 10) | (rs1 << 6) | (rs2 << 2));
    endfunction

    function automatic logic [17:0] enci(input int op, input int rd, input int rs1, input int imm);
        return 18'((op << 14) | (rd << 10) | (rs1 << 6) | imm);
    endfunction

    // opcode table: legality, immediate form, ALU function code
    function automatic bit op_legal(input int op); return op <= 5; endfunction
    function automatic bit op_imm(input int op); return op == 1 || op == 3; endfunction
    function automatic int op_fn(input int op);
        return (op <= 1) ? 0 : (op <= 3) ? 1 : (op == 4) ? 2 : 3;
    endfunction

    function automatic bit pending(input int r, input bit we, input int wa);
        return m_busy[r] && !(we && wa == r);
    endfunction

    function automatic bit m_ready(input logic [17:0] inst, input bit ordy, input bit we, input int wa);
        int op = int'(inst[17:14]);
        bit haz = pending(int'(inst[9:6]), we, wa) || pending(int'(inst[13:10]), we, wa) ||
                  (!op_imm(op) && pending(int'(inst[5:2]), we, wa));
        return (!m_valid || ordy) && !(op_legal(op) && haz);
    endfunction

    task automatic model_edge(input bit r, input bit v, input logic [17:0] inst, input bit ordy,
                              input bit we, input int wa, input int unsigned wd);
        int op = int'(inst[17:14]);
        bit take;
        if (r) begin
            m_valid = 0; m_ill = 0; m_m1 = 0; m_src1 = 0; m_src2 = 0; m_imm = 0; m_m2 = 0; m_rd = 0;
            for (int i = 0; i < 16; i++) begin m_rf[i] = 0; m_busy[i] = 0; end
            return;
        end
        take = v && m_ready(inst, ordy, we, wa);
        m_ill = take && !op_legal(op);
        if (take && op_legal(op)) begin
            int s1 = int'(inst[9:6]);
            int s2 = int'(inst[5:2]);
            m_valid = 1;
            m_src1 = (we && wa == s1) ? wd : m_rf[s1];
            m_src2 = op_imm(op) ? 0 : ((we && wa == s2) ? wd : m_rf[s2]);
            m_imm  = op_imm(op) ? int'(inst[5:0]) : 0;
            m_m1   = op_imm(op);
            m_m2   = op_fn(op);
            m_rd   = int'(inst[13:10]);
        end else if (ordy) m_valid = 0;
        if (we) begin m_rf[wa] = wd; m_busy[wa] = 0; end
        if (take && op_legal(op)) m_busy[inst[13:10]] = 1;
    endtask

    task automatic step(input bit r, input bit v, input logic [17:0] inst, input bit ordy,
                        input bit we, input int wa, input int unsigned wd);
        rst = r; in_valid = v; in_inst = inst; out_ready = ordy;
        wb_en = we; wb_addr = 4'(wa); wb_data = 18'(wd);
        #2;
        check("in_ready", in_ready, m_ready(inst, ordy, we, wa));
        @(posedge clk);
        model_edge(r, v, inst, ordy, we, wa, wd);
        #1;
        check("out_valid", out_valid, m_valid);
        check("SRC1", SRC1, m_src1);
        check("SRC2", SRC2, m_src2);
        check("IMM", IMM, m_imm);
        check("mux1_select", mux1_select, m_m1);
        check("mux2_select", mux2_select, m_m2);
        check("out_rd", out_rd, m_rd);
        check("illegal_op", illegal_op, m_ill);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin m_rf[i] = 0; m_busy[i] = 0; end
        m_valid = 0; m_ill = 0; m_m1 = 0; m_src1 = 0; m_src2 = 0; m_imm = 0; m_m2 = 0; m_rd = 0;
        rst = 1; in_valid = 0; in_inst = 0; out_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0;
        @(posedge clk); #1;
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_src1", SRC1, 0);
        check("rst_illegal", illegal_op, 0);

        step(0, 0, 0, 1, 1, 3, 5);
        step(0, 0, 0, 1, 1, 4, 10);
        step(0, 1, enc(0, 5, 3, 4), 1, 0, 0, 0);
        check("add_valid", out_valid, 1);
        check("add_src1", SRC1, 5);
        check("add_src2", SRC2, 10);
        check("add_mux", {mux2_select, mux1_select}, 0);
        check("add_rd", out_rd, 5);

        step(0, 1, enci(1, 1, 3, 6'h3E), 1, 0, 0, 0);
        check("addi_src1", SRC1, 5);
        check("addi_src2", SRC2, 0);
        check("addi_imm", IMM, 6'h3E);
        check("addi_mux", {mux2_select, mux1_select}, 3'b001);

        step(0, 1, enc(2, 6, 5, 4), 1, 0, 0, 0);
        step(0, 1, enc(2, 6, 5, 4), 1, 0, 0, 0);
        check("raw_stalled", out_valid, 0);
        step(0, 1, enc(2, 6, 5, 4), 1, 1, 5, 18'hF);
        check("raw_bypass_src1", SRC1, 18'hF);
        check("raw_mux2", mux2_select, 2'b01);
        check("raw_rd", out_rd, 6);

        step(0, 0, 0, 1, 1, 1, 18'h11);
        step(0, 0, 0, 1, 1, 6, 18'h22);
        step(0, 1, enc(5, 7, 1, 2), 1, 0, 0, 0);
        check("nor_mux2", mux2_select, 2'b11);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, enc(0, 8, 3, 4), 0, 0, 0, 0);
            check("bp_rd_hold", out_rd, 7);
            check("bp_src1_hold", SRC1, 18'h11);
        end
        step(0, 1, enc(0, 8, 3, 4), 1, 0, 0, 0);
        check("bp_release_rd", out_rd, 8);

        step(0, 1, 18'h3C000, 1, 0, 0, 0);
        check("ill_pulse", illegal_op, 1);
        check("ill_valid", out_valid, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("ill_pulse_end", illegal_op, 0);

        step(0, 1, enc(0, 5, 3, 4), 1, 0, 0, 0);
        step(0, 1, enc(0, 9, 3, 4), 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("mid_rst_valid", out_valid, 0);
        step(0, 1, enc(0, 5, 3, 4), 1, 0, 0, 0);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_src1", SRC1, 0);
        check("post_rst_src2", SRC2, 0);

        for (int n = 0; n < 3000; n++) begin
            int op = $urandom_range(0, 9);
            logic [17:0] inst;
            if (op > 5) op = $urandom_range(6, 15);
            inst = {4'(op), 14'($urandom)};
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, inst,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15), $urandom & 18'h3FFFF);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
